// File: rtl/tlb_array_sa_pkg.sv
// tlb_array_sa_pkg: Sv32 widths, PTE layout and TLB permission bundle shared by the TLB array
package tlb_array_sa_pkg;
  localparam int VPN_WIDTH = 20;
  localparam int VPN1_WIDTH = 10;
  localparam int ASID_WIDTH = 9;
  localparam int PPN_WIDTH = 22;
  localparam int PPN1_WIDTH = 12;
  localparam int ITLB_NUM_SETS = 16;
  localparam int ITLB_ASSOC = 2;
  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0] ppn0;
    logic [1:0] rsw;
    logic d, a, g, u, x, w, r, v;
  } pte_t;
  typedef struct packed {
    logic d, a, g, u, x, w, r;
  } tlb_perms_t;
endpackage

// File: rtl/tlb_array_sa_if.sv
// tlb_array_sa_if: lookup request/response, PTE fill and flush signals of the TLB array
// master drives requests, fills and flushes; slave (the array) returns responses and busy
interface tlb_array_sa_if;
  import tlb_array_sa_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [VPN_WIDTH-1:0] req_vpn;
  logic [ASID_WIDTH-1:0] req_asid;
  logic resp_valid;
  logic resp_hit;
  logic [PPN_WIDTH-1:0] resp_ppn;
  logic [7:0] resp_perms;
  logic fill_valid;
  logic [VPN_WIDTH-1:0] fill_vpn;
  logic [ASID_WIDTH-1:0] fill_asid;
  pte_t fill_pte;
  logic flush_valid;
  logic flush_by_asid;
  logic flush_by_vpn;
  logic [ASID_WIDTH-1:0] flush_asid;
  logic [VPN_WIDTH-1:0] flush_vpn;
  logic flush_busy;
  modport master (
    output req_valid, req_vpn, req_asid, fill_valid, fill_vpn, fill_asid, fill_pte,
           flush_valid, flush_by_asid, flush_by_vpn, flush_asid, flush_vpn,
    input req_ready, resp_valid, resp_hit, resp_ppn, resp_perms, flush_busy
  );
  modport slave (
    input req_valid, req_vpn, req_asid, fill_valid, fill_vpn, fill_asid, fill_pte,
          flush_valid, flush_by_asid, flush_by_vpn, flush_asid, flush_vpn,
    output req_ready, resp_valid, resp_hit, resp_ppn, resp_perms, flush_busy
  );
endinterface

// File: rtl/tlb_array_sa_plru_tree.sv
// plru_tree: tree-PLRU victim select and next-state bits for one set
// bits_i: current tree bits; way_i: touched way; victim_o: way to replace; bits_o: bits pointing away from way_i
module plru_tree #(
  parameter int ASSOC = 2,
  localparam int WW = ASSOC > 1 ? $clog2(ASSOC) : 1,
  localparam int PW = ASSOC > 1 ? ASSOC - 1 : 1
) (
  input  logic [PW-1:0] bits_i,
  input  logic [WW-1:0] way_i,
  output logic [WW-1:0] victim_o,
  output logic [PW-1:0] bits_o
);
  if (ASSOC > 1) begin : g_tree
    // heap-ordered nodes: children of n are 2n+1 (lower ways) and 2n+2 (upper ways); bit=1 points upper
    always_comb begin
      int n;
      victim_o = '0;
      bits_o = bits_i;
      n = 0;
      for (int l = 0; l < WW; l++) begin
        victim_o[WW-1-l] = bits_i[n];
        n = 2 * n + 1 + int'(bits_i[n]);
      end
      n = 0;
      for (int l = 0; l < WW; l++) begin
        bits_o[n] = !way_i[WW-1-l];
        n = 2 * n + 1 + int'(way_i[WW-1-l]);
      end
    end
  end else begin : g_none
    logic unused_way;
    assign unused_way = ^way_i;
    assign victim_o = '0;
    assign bits_o = bits_i;
  end
endmodule

// File: rtl/tlb_array_sa.sv
// tlb_array_sa: set-associative Sv32 TLB array with 1-cycle lookup, PTE fill, tree-PLRU and flush engine
// clk_i, rst_i (async, active-high); bus_if (slave): lookup req/resp, fill, flush request and flush_busy
module tlb_array_sa
  import tlb_array_sa_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int ASSOC = 2,
  parameter bit SUPERPAGE = 1'b0
) (
  input logic clk_i,
  input logic rst_i,
  tlb_array_sa_if.slave bus_if
);
  localparam int INDEX_WIDTH = $clog2(NUM_SETS);
  localparam int FW = SUPERPAGE ? VPN1_WIDTH : VPN_WIDTH;
  localparam int TAG_WIDTH = FW - INDEX_WIDTH;
  localparam int IW = INDEX_WIDTH > 0 ? INDEX_WIDTH : 1;
  localparam int WW = ASSOC > 1 ? $clog2(ASSOC) : 1;
  localparam int PW = ASSOC > 1 ? ASSOC - 1 : 1;
  localparam int PPW = SUPERPAGE ? PPN1_WIDTH : PPN_WIDTH;
  localparam logic [1:0] S_IDLE = 2'd0, S_SINGLE = 2'd1, S_WALK = 2'd2;
  // superpages are indexed and tagged by VPN1 only
  function automatic logic [FW-1:0] fld(input logic [VPN_WIDTH-1:0] vpn);
    return FW'(vpn >> (SUPERPAGE ? 10 : 0));
  endfunction
  function automatic logic [IW-1:0] idx_of(input logic [VPN_WIDTH-1:0] vpn);
    return INDEX_WIDTH > 0 ? IW'(fld(vpn)) : '0;
  endfunction
  function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [VPN_WIDTH-1:0] vpn);
    return TAG_WIDTH'(fld(vpn) >> INDEX_WIDTH);
  endfunction
  logic [ASSOC-1:0] valid_q [NUM_SETS];
  logic [ASSOC-1:0] valid_d [NUM_SETS];
  logic [TAG_WIDTH-1:0] tag_q [NUM_SETS][ASSOC];
  logic [ASID_WIDTH-1:0] asid_q [NUM_SETS][ASSOC];
  logic [PPW-1:0] ppn_q [NUM_SETS][ASSOC];
  tlb_perms_t perms_q [NUM_SETS][ASSOC];
  logic [PW-1:0] plru_q [NUM_SETS];
  logic [PW-1:0] plru_d [NUM_SETS];
  logic [1:0] state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic fl_by_asid_q;
  logic [ASID_WIDTH-1:0] fl_asid_q;
  logic [IW-1:0] fl_idx_q, fl_set;
  logic [TAG_WIDTH-1:0] fl_tag_q;
  logic resp_valid_q, resp_hit_q;
  logic [PPN_WIDTH-1:0] resp_ppn_q;
  logic [7:0] resp_perms_q;
  logic req_fire, fill_we, flush_acc;
  logic [IW-1:0] r_idx, f_idx;
  logic [TAG_WIDTH-1:0] r_tag, f_tag;
  logic [ASSOC-1:0] r_hit;
  logic [WW-1:0] r_way, f_way, f_vic, unused_r_vic;
  logic [PPW-1:0] r_ppn;
  logic [PPN_WIDTH-1:0] r_full;
  tlb_perms_t r_perms;
  logic [PW-1:0] r_plru_nxt, f_plru_nxt;
  logic unused_pte;
  assign unused_pte = ^{bus_if.fill_pte.rsw, bus_if.fill_pte.v, bus_if.fill_pte.ppn0};
  assign bus_if.req_ready = state_q == S_IDLE && !bus_if.flush_valid;
  assign bus_if.flush_busy = state_q != S_IDLE;
  assign bus_if.resp_valid = resp_valid_q;
  assign bus_if.resp_hit = resp_hit_q;
  assign bus_if.resp_ppn = resp_ppn_q;
  assign bus_if.resp_perms = resp_perms_q;
  assign req_fire = bus_if.req_valid && bus_if.req_ready;
  assign flush_acc = state_q == S_IDLE && bus_if.flush_valid;
  // a flush in the same cycle wins over a fill
  assign fill_we = bus_if.fill_valid && state_q == S_IDLE && !bus_if.flush_valid;
  assign r_idx = idx_of(bus_if.req_vpn);
  assign r_tag = tag_of(bus_if.req_vpn);
  assign f_idx = idx_of(bus_if.fill_vpn);
  assign f_tag = tag_of(bus_if.fill_vpn);
  assign fl_set = state_q == S_SINGLE ? fl_idx_q : cnt_q;
  assign r_full = SUPERPAGE ? PPN_WIDTH'({r_ppn, bus_if.req_vpn[9:0]}) : PPN_WIDTH'(r_ppn);
  always_comb begin
    r_hit = '0;
    r_way = '0;
    r_ppn = '0;
    r_perms = '0;
    for (int w = 0; w < ASSOC; w++) begin
      r_hit[w] = valid_q[r_idx][w] && tag_q[r_idx][w] == r_tag &&
                 (perms_q[r_idx][w].g || asid_q[r_idx][w] == bus_if.req_asid);
      if (r_hit[w]) begin
        r_way = WW'(w);
        r_ppn = ppn_q[r_idx][w];
        r_perms = perms_q[r_idx][w];
      end
    end
  end
  // existing matching entry beats lowest invalid way, which beats the PLRU victim
  always_comb begin
    f_way = f_vic;
    for (int w = ASSOC - 1; w >= 0; w--) if (!valid_q[f_idx][w]) f_way = WW'(w);
    for (int w = 0; w < ASSOC; w++)
      if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag &&
          (perms_q[f_idx][w].g || asid_q[f_idx][w] == bus_if.fill_asid)) f_way = WW'(w);
  end
  plru_tree #(.ASSOC(ASSOC)) u_plru_req (
    .bits_i(plru_q[r_idx]), .way_i(r_way), .victim_o(unused_r_vic), .bits_o(r_plru_nxt)
  );
  plru_tree #(.ASSOC(ASSOC)) u_plru_fill (
    .bits_i(plru_q[f_idx]), .way_i(f_way), .victim_o(f_vic), .bits_o(f_plru_nxt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    plru_d = plru_q;
    if (flush_acc) begin
      state_d = bus_if.flush_by_vpn ? S_SINGLE : S_WALK;
      cnt_d = '0;
    end
    if (state_q == S_SINGLE) state_d = S_IDLE;
    if (state_q == S_WALK) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == IW'(NUM_SETS - 1) ? S_IDLE : S_WALK;
    end
    if (state_q != S_IDLE)
      for (int w = 0; w < ASSOC; w++)
        if ((state_q == S_WALK || tag_q[fl_set][w] == fl_tag_q) &&
            (!fl_by_asid_q || (asid_q[fl_set][w] == fl_asid_q && !perms_q[fl_set][w].g)))
          valid_d[fl_set][w] = 1'b0;
    if (fill_we) valid_d[f_idx][f_way] = 1'b1;
    // fill update is applied last so it overrides a hit update to the same set
    if (req_fire && |r_hit) plru_d[r_idx] = r_plru_nxt;
    if (fill_we) plru_d[f_idx] = f_plru_nxt;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '{default: '0};
      plru_q <= '{default: '0};
      state_q <= S_IDLE;
      cnt_q <= '0;
      fl_by_asid_q <= 1'b0;
      fl_asid_q <= '0;
      fl_idx_q <= '0;
      fl_tag_q <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_ppn_q <= '0;
      resp_perms_q <= '0;
    end else begin
      valid_q <= valid_d;
      plru_q <= plru_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (flush_acc) begin
        fl_by_asid_q <= bus_if.flush_by_asid;
        fl_asid_q <= bus_if.flush_asid;
        fl_idx_q <= idx_of(bus_if.flush_vpn);
        fl_tag_q <= tag_of(bus_if.flush_vpn);
      end
      resp_valid_q <= req_fire;
      resp_hit_q <= req_fire && |r_hit;
      resp_ppn_q <= req_fire && |r_hit ? r_full : '0;
      resp_perms_q <= req_fire && |r_hit ? {r_perms, 1'b1} : '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[f_idx][f_way] <= f_tag;
      asid_q[f_idx][f_way] <= bus_if.fill_asid;
      ppn_q[f_idx][f_way] <= PPW'({bus_if.fill_pte.ppn1, bus_if.fill_pte.ppn0} >> (SUPERPAGE ? 10 : 0));
      perms_q[f_idx][f_way] <= tlb_perms_t'(bus_if.fill_pte[7:1]);
    end
  end
endmodule

// File: tb/tb_tlb_array_sa.sv
// tb_tlb_array_sa: directed self-checking bench for tlb_array_sa (4-way 4KB and 2-way 4MB instances)
module tb_tlb_array_sa;
  import tlb_array_sa_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  logic l_vld, l_hit;
  logic [21:0] l_ppn;
  logic [7:0] l_perms;
  logic [19:0] v [5] = '{20'h00015, 20'h00025, 20'h00035, 20'h00045, 20'h00055};
  tlb_array_sa_if if4 ();
  tlb_array_sa_if ifs ();
  tlb_array_sa #(.NUM_SETS(16), .ASSOC(4), .SUPERPAGE(1'b0)) u4 (.clk_i(clk), .rst_i(rst), .bus_if(if4));
  tlb_array_sa #(.NUM_SETS(16), .ASSOC(2), .SUPERPAGE(1'b1)) us (.clk_i(clk), .rst_i(rst), .bus_if(ifs));
  always #5 clk = ~clk;
  task automatic fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn, input logic [7:0] fl);
    @(negedge clk);
    if4.fill_valid = 1'b1;
    if4.fill_vpn = vpn;
    if4.fill_asid = asid;
    if4.fill_pte = {ppn, 2'b00, fl};
    @(posedge clk);
    #1 if4.fill_valid = 1'b0;
  endtask
  task automatic look(input logic [19:0] vpn, input logic [8:0] asid);
    @(negedge clk);
    if4.req_valid = 1'b1;
    if4.req_vpn = vpn;
    if4.req_asid = asid;
    @(posedge clk);
    #1 if4.req_valid = 1'b0;
    l_vld = if4.resp_valid;
    l_hit = if4.resp_hit;
    l_ppn = if4.resp_ppn;
    l_perms = if4.resp_perms;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if (if4.flush_busy !== 1'b0 || ifs.flush_busy !== 1'b0) $display("FAIL reset_busy: got %b/%b want 0/0", if4.flush_busy, ifs.flush_busy); else n_pass++;
    n_total++; if ({if4.resp_valid, if4.resp_hit, if4.resp_ppn, if4.resp_perms} !== 32'h0) $display("FAIL reset_resp: got %b %b %h %h want all 0", if4.resp_valid, if4.resp_hit, if4.resp_ppn, if4.resp_perms); else n_pass++;
    n_total++; if (if4.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if4.req_ready); else n_pass++;
    rst = 1'b0;
  endtask
  task automatic test_basic();
    fill(20'h12345, 9'd3, 22'h2ABCD, 8'h0F);
    look(20'h12345, 9'd3);
    n_total++; if ({l_vld, l_hit, l_ppn, l_perms} !== {1'b1, 1'b1, 22'h2ABCD, 8'h0F}) $display("FAIL basic_hit: got v=%b h=%b ppn=%h perms=%h want 1 1 2abcd 0f", l_vld, l_hit, l_ppn, l_perms); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (if4.resp_valid !== 1'b0) $display("FAIL basic_one_cycle: got resp_valid=%b want 0", if4.resp_valid); else n_pass++;
    look(20'h12345, 9'd4);
    n_total++; if ({l_vld, l_hit, l_ppn, l_perms} !== {1'b1, 1'b0, 22'h0, 8'h0}) $display("FAIL basic_asid_miss: got v=%b h=%b ppn=%h perms=%h want 1 0 0 0", l_vld, l_hit, l_ppn, l_perms); else n_pass++;
  endtask
  task automatic test_flush_all();
    int busy = 0;
    @(negedge clk);
    if4.flush_valid = 1'b1; if4.flush_by_vpn = 1'b0; if4.flush_by_asid = 1'b0;
    @(posedge clk);
    #1 if4.flush_valid = 1'b0;
    for (int i = 0; i < 100 && if4.flush_busy; i++) begin busy++; @(posedge clk); #1; end
    n_total++; if (busy != 16) $display("FAIL walk_all_busy: got %0d cycles want 16", busy); else n_pass++;
    look(20'h12345, 9'd3);
    n_total++; if ({l_vld, l_hit} !== 2'b10) $display("FAIL walk_all_miss: got v=%b h=%b want 1 0", l_vld, l_hit); else n_pass++;
  endtask
  task automatic test_fill_timing();
    @(negedge clk);
    if4.fill_valid = 1'b1; if4.fill_vpn = 20'h00077; if4.fill_asid = 9'd2; if4.fill_pte = {22'h00777, 2'b00, 8'h03};
    if4.req_valid = 1'b1; if4.req_vpn = 20'h00077; if4.req_asid = 9'd2;
    @(posedge clk);
    #1 if4.fill_valid = 1'b0; if4.req_valid = 1'b0;
    n_total++; if ({if4.resp_valid, if4.resp_hit} !== 2'b10) $display("FAIL same_cycle_fill: got v=%b h=%b want 1 0", if4.resp_valid, if4.resp_hit); else n_pass++;
    look(20'h00077, 9'd2);
    n_total++; if ({l_hit, l_ppn, l_perms} !== {1'b1, 22'h00777, 8'h03}) $display("FAIL next_cycle_hit: got h=%b ppn=%h perms=%h want 1 777 03", l_hit, l_ppn, l_perms); else n_pass++;
  endtask
  task automatic test_plru();
    int hit_ix [4] = '{0, 2, 3, 4};
    for (int i = 0; i < 4; i++) fill(v[i], 9'd1, 22'(256 + i), 8'h0F);
    look(v[0], 9'd1);
    n_total++; if ({l_hit, l_ppn} !== {1'b1, 22'h100}) $display("FAIL plru_touch_a: got h=%b ppn=%h want 1 100", l_hit, l_ppn); else n_pass++;
    look(v[2], 9'd1);
    n_total++; if ({l_hit, l_ppn} !== {1'b1, 22'h102}) $display("FAIL plru_touch_c: got h=%b ppn=%h want 1 102", l_hit, l_ppn); else n_pass++;
    fill(v[4], 9'd1, 22'h104, 8'h0F);
    look(v[1], 9'd1);
    n_total++; if ({l_vld, l_hit, l_ppn} !== {1'b1, 1'b0, 22'h0}) $display("FAIL plru_evict_b: got v=%b h=%b ppn=%h want 1 0 0", l_vld, l_hit, l_ppn); else n_pass++;
    foreach (hit_ix[k]) begin
      look(v[hit_ix[k]], 9'd1);
      n_total++; if ({l_hit, l_ppn} !== {1'b1, 22'(256 + hit_ix[k])}) $display("FAIL plru_keep_%0d: got h=%b ppn=%h want 1 %h", hit_ix[k], l_hit, l_ppn, 22'(256 + hit_ix[k])); else n_pass++;
    end
    fill(v[2], 9'd1, 22'h999, 8'h0F);
    foreach (hit_ix[k]) begin
      look(v[hit_ix[k]], 9'd1);
      n_total++; if ({l_hit, l_ppn} !== {1'b1, hit_ix[k] == 2 ? 22'h999 : 22'(256 + hit_ix[k])}) $display("FAIL refill_%0d: got h=%b ppn=%h", hit_ix[k], l_hit, l_ppn); else n_pass++;
    end
  endtask
  task automatic test_superpage();
    @(negedge clk);
    ifs.fill_valid = 1'b1; ifs.fill_vpn = 20'h0C800; ifs.fill_asid = 9'd2; ifs.fill_pte = {12'h123, 10'h000, 2'b00, 8'h0F};
    @(posedge clk);
    #1 ifs.fill_valid = 1'b0;
    foreach (v[i]) begin
      @(negedge clk);
      ifs.req_valid = 1'b1; ifs.req_vpn = i == 0 ? 20'h0C9FF : 20'h0CC00; ifs.req_asid = 9'd2;
      @(posedge clk);
      #1 ifs.req_valid = 1'b0;
      if (i == 0) begin
        n_total++; if ({ifs.resp_hit, ifs.resp_ppn, ifs.resp_perms} !== {1'b1, 22'h48DFF, 8'h0F}) $display("FAIL super_hit: got h=%b ppn=%h perms=%h want 1 48dff 0f", ifs.resp_hit, ifs.resp_ppn, ifs.resp_perms); else n_pass++;
      end else if (i == 1) begin
        n_total++; if ({ifs.resp_valid, ifs.resp_hit} !== 2'b10) $display("FAIL super_next_page: got v=%b h=%b want 1 0", ifs.resp_valid, ifs.resp_hit); else n_pass++;
      end
    end
  endtask
  task automatic test_flush_asid();
    int busy = 0;
    int ready_seen = 0;
    fill(20'h00100, 9'd7, 22'h00AAA, 8'h2F);
    fill(20'h00201, 9'd3, 22'h00BBB, 8'h0F);
    fill(20'h00302, 9'd5, 22'h00CCC, 8'h0F);
    fill(20'h0040F, 9'd3, 22'h00DDD, 8'h0F);
    @(negedge clk);
    if4.flush_valid = 1'b1; if4.flush_by_vpn = 1'b0; if4.flush_by_asid = 1'b1; if4.flush_asid = 9'd3;
    #1;
    n_total++; if (if4.req_ready !== 1'b0) $display("FAIL ready_on_flush_valid: got %b want 0", if4.req_ready); else n_pass++;
    @(posedge clk);
    #1 if4.flush_valid = 1'b0;
    for (int i = 0; i < 100 && if4.flush_busy; i++) begin busy++; ready_seen += int'(if4.req_ready); @(posedge clk); #1; end
    n_total++; if (busy != 16) $display("FAIL asid_flush_busy: got %0d cycles want 16", busy); else n_pass++;
    n_total++; if (ready_seen != 0) $display("FAIL asid_flush_ready: got ready in %0d busy cycles want 0", ready_seen); else n_pass++;
    look(20'h00100, 9'd3);
    n_total++; if ({l_hit, l_ppn, l_perms} !== {1'b1, 22'h00AAA, 8'h2F}) $display("FAIL asid_flush_global: got h=%b ppn=%h perms=%h want 1 aaa 2f", l_hit, l_ppn, l_perms); else n_pass++;
    look(20'h00302, 9'd5);
    n_total++; if ({l_hit, l_ppn} !== {1'b1, 22'h00CCC}) $display("FAIL asid_flush_keep5: got h=%b ppn=%h want 1 ccc", l_hit, l_ppn); else n_pass++;
    look(20'h00201, 9'd3);
    n_total++; if (l_hit !== 1'b0) $display("FAIL asid_flush_drop3a: got h=%b want 0", l_hit); else n_pass++;
    look(20'h0040F, 9'd3);
    n_total++; if (l_hit !== 1'b0) $display("FAIL asid_flush_drop3b: got h=%b want 0", l_hit); else n_pass++;
    look(v[0], 9'd1);
    n_total++; if (l_hit !== 1'b1) $display("FAIL asid_flush_keep1: got h=%b want 1", l_hit); else n_pass++;
  endtask
  task automatic test_flush_vpn_fill();
    fill(20'h00018, 9'd1, 22'h00018, 8'h0F);
    fill(20'h00028, 9'd1, 22'h00028, 8'h0F);
    @(negedge clk);
    if4.flush_valid = 1'b1; if4.flush_by_vpn = 1'b1; if4.flush_by_asid = 1'b0; if4.flush_vpn = 20'h00018;
    if4.fill_valid = 1'b1; if4.fill_vpn = 20'h00038; if4.fill_asid = 9'd1; if4.fill_pte = {22'h00038, 2'b00, 8'h0F};
    @(posedge clk);
    #1 if4.flush_valid = 1'b0; if4.fill_valid = 1'b0;
    n_total++; if (if4.flush_busy !== 1'b1) $display("FAIL single_busy: got %b want 1", if4.flush_busy); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (if4.flush_busy !== 1'b0) $display("FAIL single_done: got %b want 0", if4.flush_busy); else n_pass++;
    look(20'h00018, 9'd1);
    n_total++; if (l_hit !== 1'b0) $display("FAIL single_target: got h=%b want 0", l_hit); else n_pass++;
    look(20'h00028, 9'd1);
    n_total++; if ({l_hit, l_ppn} !== {1'b1, 22'h00028}) $display("FAIL single_keep: got h=%b ppn=%h want 1 28", l_hit, l_ppn); else n_pass++;
    look(20'h00038, 9'd1);
    n_total++; if (l_hit !== 1'b0) $display("FAIL single_fill_drop: got h=%b want 0", l_hit); else n_pass++;
  endtask
  task automatic test_reset_mid_walk();
    @(negedge clk);
    if4.flush_valid = 1'b1; if4.flush_by_vpn = 1'b0; if4.flush_by_asid = 1'b0;
    @(posedge clk);
    #1 if4.flush_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if (if4.flush_busy !== 1'b0) $display("FAIL rst_walk_busy: got %b want 0", if4.flush_busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if ({if4.req_ready, if4.resp_valid} !== 2'b10) $display("FAIL rst_walk_ready: got ready=%b resp_valid=%b want 1 0", if4.req_ready, if4.resp_valid); else n_pass++;
    look(20'h00028, 9'd1);
    n_total++; if ({l_vld, l_hit} !== 2'b10) $display("FAIL rst_walk_set8: got v=%b h=%b want 1 0", l_vld, l_hit); else n_pass++;
    look(v[0], 9'd1);
    n_total++; if (l_hit !== 1'b0) $display("FAIL rst_walk_set5: got h=%b want 0", l_hit); else n_pass++;
    look(20'h00100, 9'd7);
    n_total++; if (l_hit !== 1'b0) $display("FAIL rst_walk_global: got h=%b want 0", l_hit); else n_pass++;
  endtask
  initial begin
    if4.req_valid = 1'b0; if4.req_vpn = '0; if4.req_asid = '0;
    if4.fill_valid = 1'b0; if4.fill_vpn = '0; if4.fill_asid = '0; if4.fill_pte = '0;
    if4.flush_valid = 1'b0; if4.flush_by_asid = 1'b0; if4.flush_by_vpn = 1'b0; if4.flush_asid = '0; if4.flush_vpn = '0;
    ifs.req_valid = 1'b0; ifs.req_vpn = '0; ifs.req_asid = '0;
    ifs.fill_valid = 1'b0; ifs.fill_vpn = '0; ifs.fill_asid = '0; ifs.fill_pte = '0;
    ifs.flush_valid = 1'b0; ifs.flush_by_asid = 1'b0; ifs.flush_by_vpn = 1'b0; ifs.flush_asid = '0; ifs.flush_vpn = '0;
    test_reset();
    test_basic();
    test_flush_all();
    test_fill_timing();
    test_plru();
    test_superpage();
    test_flush_asid();
    test_flush_vpn_fill();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
